mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencing controller, sitting in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from the decoded E-stage instruction and owns the architectural HI/LO registers.
- Drives busy, which hazard control uses to stall the D stage on MDU-dependent instructions.
- Honours an exception/interrupt flush so that a cancelled instruction never alters HI/LO.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- MDUOp  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- flush  input  1  exception/interrupt taken this cycle; suppresses any MDUOp sampled this cycle.
- rs_data  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_data  input  32  forwarded rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, count=0, busy=0, hi=0, lo=0, pending result=0.
  - Reset mid-operation abandons the operation; HI/LO read 0 afterwards.
- States: IDLE, RUN.
- IDLE, op 1-4 with flush=0:
  - At the edge, compute the full 64-bit result into pending registers, load count with MULT_CYCLES or DIV_CYCLES, go to RUN, busy=1.
- IDLE, op 5/6 with flush=0: at the edge, hi<=rs_data (5) or lo<=rs_data (6). Single cycle; busy stays 0.
- IDLE, flush=1: op ignored entirely; no state, HI or LO change.
- RUN: count decrements each edge.
- RUN, edge where count==1:
  - Commit pending to {hi,lo}, return to IDLE, busy=0 from that edge.
  - busy is therefore high for exactly N cycles after the start edge; the new HI/LO are visible in the same cycle busy falls.
- RUN: MDUOp and flush are ignored. Hazard control stalls MDU ops while busy, and flush does not cancel an op that has already started (it is architecturally committed).
- mult: signed 32x32 -> 64; hi=upper, lo=lower. multu: unsigned.
- div/divu:
  - lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) -> lo=0x80000000, hi=0.
- Divide by zero (rt_data==0): full DIV_CYCLES busy period still runs; at completion HI/LO are left unchanged.
- Stall condition for hazard control is (MDUOp in 1..4) | busy. The controller does not generate this signal; it only provides busy.

Test Plan:
- Reset, then mult rs=0xFFFFFFFE (-2), rt=3 -> busy high for 5 cycles; on busy fall hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu of the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- mthi rs=0x12345678, next cycle mtlo rs=0x9ABCDEF0 -> hi and lo update one edge each, busy never asserts. div by rt=0 afterwards -> busy 10 cycles, hi/lo remain 0x12345678/0x9ABCDEF0.
- div with flush=1 on the same cycle -> busy stays 0, hi/lo unchanged. mult started, then flush=1 mid-RUN -> operation completes normally.
- reset asserted asynchronously at RUN count=3 -> busy, hi and lo drop to 0 immediately. The next mult after release runs the full 5 cycles.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit and its sequencing controller.
// It owns the architectural HI/LO registers. The full result is computed when
// an op is accepted and committed after the configured busy period.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDUOp,
  input  logic        flush,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_skip;

  logic [63:0] mul_s, mul_u;
  logic [31:0] abs_a, abs_b, div_b, q_mag, r_mag;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic        div_zero;

  // Result datapath: products plus sign-magnitude division.
  // Going through magnitudes keeps 0x80000000 / -1 well defined (q=0x80000000, r=0).
  always_comb begin
    mul_s    = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    mul_u    = {32'd0, rs_data} * {32'd0, rt_data};
    div_zero = (rt_data == 32'd0);
    div_b    = div_zero ? 32'd1 : rt_data;
    q_u      = rs_data / div_b;
    r_u      = rs_data % div_b;
    abs_a    = rs_data[31] ? (32'd0 - rs_data) : rs_data;
    abs_b    = div_b[31] ? (32'd0 - div_b) : div_b;
    q_mag    = abs_a / abs_b;
    r_mag    = abs_a % abs_b;
    q_s      = (rs_data[31] ^ div_b[31]) ? (32'd0 - q_mag) : q_mag;
    r_s      = rs_data[31] ? (32'd0 - r_mag) : r_mag;
  end

  // Sequencer: accept in IDLE, count down in RUN, commit on the last edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_skip <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush) begin
            case (MDUOp)
              OP_MULT, OP_MULTU: begin
                {pend_hi, pend_lo} <= (MDUOp == OP_MULT) ? mul_s : mul_u;
                pend_skip          <= 1'b0;
                count              <= CNT_W'(MULT_CYCLES);
                state              <= RUN;
                busy               <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi   <= (MDUOp == OP_DIV) ? r_s : r_u;
                pend_lo   <= (MDUOp == OP_DIV) ? q_s : q_u;
                pend_skip <= div_zero;
                count     <= CNT_W'(DIV_CYCLES);
                state     <= RUN;
                busy      <= 1'b1;
              end
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!pend_skip) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
